mcycle_unit: RTL and testbench
==============================

# mcycle_unit

Iterative multi-cycle arithmetic unit that executes the MUL and DIV instructions issued by the instruction decoder's multi-cycle start/op controls. It sits beside the ALU in the execute stage. On `Start` it latches two 32-bit operands and runs one of two algorithms, each taking 32 iterations:
- unsigned shift-add multiply;
- unsigned restoring divide.

While it computes it holds `Busy` high so the pipeline stalls. When it finishes it presents a two-word result for register write-back.

## Interface
- `WIDTH`, 32, operand and result width. Only 32 is verified.
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `Start`  in  1  request a new operation. Sampled only in IDLE.
- `MCycleOp`  in  1  operation select: 0 = multiply, 1 = divide.
- `Operand1`  in  WIDTH  multiplicand or dividend.
- `Operand2`  in  WIDTH  multiplier or divisor.
- `Result1`  out  WIDTH  multiply: product[31:0]; divide: quotient.
- `Result2`  out  WIDTH  multiply: product[63:32]; divide: remainder.
- `Busy`  out  1  operation accepted or in progress; the pipeline stalls while it is high.

## Operation
- States: IDLE, COMPUTING, DONE.
- IDLE:
  - `Start`=1 → latch `Operand1`, `Operand2` and `MCycleOp` into internal registers, clear the iteration counter, go to COMPUTING.
  - `Start`=0 → stay in IDLE.
- COMPUTING: one iteration per cycle; the counter increments each cycle. After iteration 32 the unit writes `Result1`/`Result2` and goes to DONE.
- DONE: lasts exactly one cycle, then IDLE. `Start` is ignored in DONE, so the still-resident instruction cannot re-trigger the unit.
- Multiply (shift-add):
  - Datapath: 64-bit product accumulator, shifted multiplier register, 32-bit adder.
  - Each iteration: if the multiplier LSB is 1, add the multiplicand into the upper half of the accumulator, keeping the 33-bit carry. Then shift the accumulator right by 1 and the multiplier right by 1.
  - All arithmetic is unsigned and modulo 2^64.
- Divide (restoring):
  - Datapath: 33-bit partial remainder, 32-bit quotient shift register.
  - Each iteration: shift in the next dividend bit from the MSB down, then subtract the divisor.
    - Result non-negative → keep the difference and shift a 1 into the quotient.
    - Result negative → restore the remainder and shift in a 0.
  - Unsigned.
- Divide by zero: the algorithm runs unmodified. The required result is `Result1`=0xFFFFFFFF, `Result2`=dividend.
- Operands are latched at acceptance; input changes during COMPUTING have no effect.
- `Start` while COMPUTING or DONE: ignored, with no queuing.
- `Result1`/`Result2` are registered and hold their value until the next operation completes.
- `Busy` = (state==IDLE & `Start`) | (state==COMPUTING). It is combinational so the stall begins in the issue cycle.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, counter=0, `Result1`=0, `Result2`=0, all internal operand registers 0.
  - `Busy`=0 unless `Start` is high. `Busy` is derived combinationally, so it can read 1 during reset if `Start` is asserted.
- Reset asserted mid-operation aborts the operation. The results are cleared to 0, not left as partial values.
- Issue cycle C0: IDLE with `Start`=1; `Busy`=1.
- Cycles C1..C32: COMPUTING; `Busy`=1.
- At the C32 rising edge the results are registered.
- C33: DONE; `Busy`=0; results valid. Write-back occurs in this cycle.
- C34: IDLE; a new `Start` can be accepted here.
- Latency: 33 cycles from issue to valid results, with `Busy` high for 33 cycles.
- Back-to-back operations: minimum issue spacing is 34 cycles.
- The iteration count is fixed at 32 for both ops. There is no early termination on zero operands.

## Test plan
- Small multiply: `MCycleOp`=0, 7 × 6 → `Busy` high for exactly 33 cycles; then `Result1`=0x0000002A, `Result2`=0.
- Full-width multiply: 0xFFFFFFFF × 0xFFFFFFFF → `Result1`=0x00000001, `Result2`=0xFFFFFFFE.
- Divide: 100 ÷ 7 → `Result1`=14, `Result2`=2. Also 0x80000000 ÷ 0x00000003 → `Result1`=0x2AAAAAAA, `Result2`=2.
- Divide by zero: 0x00001234 ÷ 0 → `Result1`=0xFFFFFFFF, `Result2`=0x00001234, with latency unchanged.
- Operand and start robustness:
  - Start 5 × 5. In C1, change the operands to 9 × 9 and hold `Start` high through C33.
  - Required: result 25; no restart in DONE; a new operation begins only in C34.
- Reset mid-op: start 3 × 4 and assert `RESET` in C10 → immediately IDLE, `Busy`=0, results 0. Then a fresh 3 × 4 after reset → `Result1`=12.

Source files
------------

// File: rtl/mcycle_unit.sv
// rtl/mcycle_unit.sv - iterative 32-step unsigned shift-add multiply / restoring divide
`timescale 1ns/1ps
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, COMPUTING, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q;
  logic               op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   res1_q, res2_q;

  logic               last_iter;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_d;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quot_d;

  assign last_iter = (count_q == CW'(WIDTH - 1));

  // Multiplier lives in the low half of the accumulator and shifts out as product bits shift in.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

  // Dividend shifts out of a_q MSB-first while quotient bits shift in at the bottom.
  assign div_sh   = {rem_q, a_q[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, b_q});
  assign div_diff = div_sh[WIDTH-1:0] - b_q;
  assign rem_d    = div_ge ? div_diff : div_sh[WIDTH-1:0];
  assign quot_d   = {a_q[WIDTH-2:0], div_ge};

  always_comb begin
    state_d = state_q;
    Busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = COMPUTING;
          Busy    = 1'b1;
        end
      end
      COMPUTING: begin
        Busy = 1'b1;
        if (last_iter) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && Start) begin
        count_q <= '0;
        op_q    <= MCycleOp;
        a_q     <= Operand1;
        b_q     <= Operand2;
        acc_q   <= {{WIDTH{1'b0}}, Operand2};
        rem_q   <= '0;
      end else if (state_q == COMPUTING) begin
        count_q <= count_q + 1'b1;
        if (op_q) begin
          rem_q <= rem_d;
          a_q   <= quot_d;
        end else begin
          acc_q <= mul_acc_d;
        end
        if (last_iter) begin
          res1_q <= op_q ? quot_d : mul_acc_d[WIDTH-1:0];
          res2_q <= op_q ? rem_d  : mul_acc_d[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

  assign Result1 = res1_q;
  assign Result2 = res2_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// tb/tb_mcycle_unit.sv - directed and randomized checks of mcycle_unit against an arithmetic model
`timescale 1ns/1ps
module tb_mcycle_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Start;
  logic        MCycleOp;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic [31:0] Result1;
  logic [31:0] Result2;
  logic        Busy;

  int total  = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  mcycle_unit #(.WIDTH(32)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Returns {Result2, Result1}.
  function automatic logic [63:0] model(input logic op, input logic [31:0] a, input logic [31:0] b);
    if (!op) return {32'd0, a} * {32'd0, b};
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  // Entered at the sample point of the issue cycle; counts Busy cycles up to DONE.
  task automatic wait_done(input bit hold_start, output int busy_n);
    busy_n = 0;
    while (Busy && busy_n < 100) begin
      busy_n++;
      @(negedge CLK);
      if (!hold_start) Start = 1'b0;
      #1;
    end
  endtask

  task automatic run_check(input string tag, input logic op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
    int n;
    @(negedge CLK);
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    #1;
    wait_done(1'b0, n);
    check({tag, " latency"}, 64'(n), 64'd33);
    check(tag, {Result2, Result1}, exp);
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;
    logic        rop;

    RESET = 1'b1; Start = 1'b0; MCycleOp = 1'b0; Operand1 = '0; Operand2 = '0;
    repeat (2) @(negedge CLK);
    #1;
    check("reset busy", 64'(Busy), 64'd0);
    check("reset results", {Result2, Result1}, 64'd0);
    Start = 1'b1;
    #1;
    check("reset busy with start", 64'(Busy), 64'd1);
    Start = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;

    run_check("mul 7x6", 1'b0, 32'd7, 32'd6, 64'h0000_0000_0000_002A);
    repeat (3) @(negedge CLK);
    #1;
    check("result hold", {Result2, Result1}, 64'h0000_0000_0000_002A);
    run_check("mul full", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_check("div 100/7", 1'b1, 32'd100, 32'd7, {32'd2, 32'd14});
    run_check("div 8000_0000/3", 1'b1, 32'h8000_0000, 32'd3, {32'd2, 32'h2AAA_AAAA});
    run_check("div by zero", 1'b1, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF});

    @(negedge CLK);
    Start = 1'b1; MCycleOp = 1'b0; Operand1 = 32'd5; Operand2 = 32'd5;
    #1;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      @(negedge CLK);
      Operand1 = 32'd9; Operand2 = 32'd9;
      #1;
    end
    check("held start latency", 64'(n), 64'd33);
    check("latched operands", {Result2, Result1}, 64'd25);
    check("no restart in done", 64'(Busy), 64'd0);
    @(negedge CLK);
    #1;
    check("restart in C34", 64'(Busy), 64'd1);
    wait_done(1'b0, n);
    check("restart latency", 64'(n), 64'd33);
    check("restart result", {Result2, Result1}, 64'd81);

    @(negedge CLK);
    Start = 1'b1; MCycleOp = 1'b0; Operand1 = 32'd3; Operand2 = 32'd4;
    @(negedge CLK);
    Start = 1'b0;
    repeat (9) @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("mid-op reset busy", 64'(Busy), 64'd0);
    check("mid-op reset results", {Result2, Result1}, 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("post reset idle", 64'(Busy), 64'd0);
    run_check("mul 3x4 after reset", 1'b0, 32'd3, 32'd4, 64'd12);

    for (int i = 0; i < 16; i++) begin
      rop = 1'($urandom_range(1));
      ra  = $urandom;
      case ($urandom_range(3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(255));
        default: rb = $urandom;
      endcase
      run_check($sformatf("rand %0d op%0d %0h,%0h", i, rop, ra, rb), rop, ra, rb, model(rop, ra, rb));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
